// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR controller. One external 16x16
// signed multiplier is stepped through every tap for each accepted sample;
// this block owns the delay line, the coefficient file and the accumulator,
// and hands each filter result downstream on a valid/ready stream.
module fir_mac_sequencer #(
    parameter int NTAPS = 16,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int PW    = 31,
    parameter int ACC_W = 35
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DW-1:0]            s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [ACC_W-1:0]         m_data,
    input  logic                     cfg_we,
    input  logic [$clog2(NTAPS)-1:0] cfg_addr,
    input  logic [CW-1:0]            cfg_data,
    output logic                     cfg_busy,
    output logic [DW-1:0]            mul_a,
    output logic [CW-1:0]            mul_b,
    input  logic [PW-1:0]            mul_p
);

    localparam int KW = $clog2(NTAPS);
    localparam logic [KW-1:0] LAST_TAP = KW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [KW-1:0]    k;
    logic [ACC_W-1:0] acc;
    logic [DW-1:0]    x    [NTAPS];
    logic [CW-1:0]    coef [NTAPS];

    logic             accept;
    logic             cfg_wr;
    logic [ACC_W-1:0] prod_ext;

    // The product is taken exactly as delivered, including the multiplier's
    // own wrap of the most-negative square; only sign extension happens here.
    assign prod_ext = {{(ACC_W - PW){mul_p[PW-1]}}, mul_p};
    assign accept   = s_valid && s_ready;
    assign cfg_wr   = cfg_we && (state == IDLE);

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and all handshake/multiplier outputs; everything idles at zero.
    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        m_data   = '0;
        cfg_busy = 1'b0;
        mul_a    = '0;
        mul_b    = '0;
        case (state)
            IDLE: begin
                // Gated by reset so s_ready is low while reset is held.
                s_ready = ap_rst_n;
                if (s_valid && ap_rst_n) begin
                    state_nx = MAC;
                end
            end
            MAC: begin
                cfg_busy = 1'b1;
                mul_a    = x[k];
                mul_b    = coef[k];
                if (k == LAST_TAP) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                cfg_busy = 1'b1;
                m_valid  = 1'b1;
                m_data   = acc;
                if (m_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Tap counter and accumulator: cleared on acceptance, one MAC per cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            k   <= '0;
            acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        k   <= '0;
                        acc <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    k   <= k + KW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Sample delay line, shifted once per accepted sample.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int unsigned j = 0; j < NTAPS; j++) begin
                x[j] <= '0;
            end
        end else if (accept) begin
            x[0] <= s_data;
            for (int unsigned j = 1; j < NTAPS; j++) begin
                x[j] <= x[j-1];
            end
        end
    end

    // Coefficient file; writes land only in IDLE so a write coincident with
    // an accepted sample is already visible in the first MAC cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int unsigned j = 0; j < NTAPS; j++) begin
                coef[j] <= '0;
            end
        end else if (cfg_wr) begin
            coef[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer: external multiplier model, reference FIR
// model feeding an expected-result queue, observed results compared per test.
module tb_fir_mac_sequencer;

    localparam int NTAPS = 16;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int PW    = 31;
    localparam int ACC_W = 35;
    localparam int KW    = 4;

    logic             ap_clk;
    logic             ap_rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
    logic             m_valid;
    logic             m_ready;
    logic [ACC_W-1:0] m_data;
    logic             cfg_we;
    logic [KW-1:0]    cfg_addr;
    logic [CW-1:0]    cfg_data;
    logic             cfg_busy;
    logic [DW-1:0]    mul_a;
    logic [CW-1:0]    mul_b;
    logic [PW-1:0]    mul_p;

    logic signed [DW+CW-1:0] mul_full;
    assign mul_full = $signed(mul_a) * $signed(mul_b);
    assign mul_p    = mul_full[PW-1:0];

    fir_mac_sequencer #(
        .NTAPS(NTAPS),
        .DW   (DW),
        .CW   (CW),
        .PW   (PW),
        .ACC_W(ACC_W)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .cfg_we  (cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_busy(cfg_busy),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_p   (mul_p)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic signed [DW-1:0] mx [NTAPS];
    logic signed [CW-1:0] mc [NTAPS];

    logic [ACC_W-1:0] exp_q [$];
    logic [ACC_W-1:0] got_q [$];
    int               acc_e_q [$];
    int               got_e_q [$];

    task automatic model_clear();
        for (int j = 0; j < NTAPS; j++) begin
            mx[j] = '0;
            mc[j] = '0;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        acc_e_q.delete();
        got_e_q.delete();
    endtask

    // Observe the handshakes about to happen at the next edge, update the
    // reference model, then advance one clock to the following negedge.
    task automatic tick();
        logic signed [DW+CW-1:0] pf;
        logic [ACC_W-1:0]        am;
        if (ap_rst_n && cfg_we && !cfg_busy) mc[cfg_addr] = cfg_data;
        if (s_valid && s_ready) begin
            for (int j = NTAPS - 1; j > 0; j--) mx[j] = mx[j-1];
            mx[0] = s_data;
            am = '0;
            for (int j = 0; j < NTAPS; j++) begin
                pf = mx[j] * mc[j];
                am = am + {{(ACC_W - PW){pf[PW-1]}}, pf[PW-1:0]};
            end
            exp_q.push_back(am);
            acc_e_q.push_back(cyc);
        end
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            got_e_q.push_back(cyc);
        end
        @(posedge ap_clk);
        cyc++;
        @(negedge ap_clk);
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit took;
        took    = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 200 && !took; i++) begin
            took = s_ready;
            tick();
        end
        s_valid = 1'b0;
        if (!took) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: s_ready never high within 200 cycles (required 1)");
        end
    endtask

    task automatic cfg_write(input int a, input logic [CW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = KW'(a);
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (got_q.size() < exp_q.size() && i < 400) begin
            tick();
            i++;
        end
        if (got_q.size() < exp_q.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic flush_zeros();
        for (int i = 0; i < NTAPS; i++) send('0);
        drain();
        clear_sb();
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        model_clear();
        clear_sb();
        tick();
        tick();
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %0h required 0", m_data); end
        n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_busy: got %b required 0", cfg_busy); end
        n_checks++; if (mul_a !== '0) begin n_fail++; $display("FAIL reset_mul_a: got %0h required 0", mul_a); end
        n_checks++; if (mul_b !== '0) begin n_fail++; $display("FAIL reset_mul_b: got %0h required 0", mul_b); end
        ap_rst_n = 1'b1;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL release_s_ready: got %b required 1", s_ready); end
    endtask

    task automatic test_impulse();
        logic [ACC_W-1:0] want;
        for (int k = 0; k < NTAPS; k++) cfg_write(k, CW'(k + 1));
        clear_sb();
        send(16'd1);
        for (int i = 0; i < NTAPS + 1; i++) send('0);
        drain();
        n_checks++; if (got_q.size() != NTAPS + 2) begin n_fail++; $display("FAIL impulse_count: got %0d required %0d", got_q.size(), NTAPS + 2); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            want = (i < NTAPS) ? ACC_W'(i + 1) : '0;
            n_checks++; if (got_q[i] !== want) begin n_fail++; $display("FAIL impulse_y[%0d]: got %0d required %0d", i, got_q[i], want); end
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL impulse_model[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); end
            n_checks++; if (got_e_q[i] - acc_e_q[i] != NTAPS + 1) begin n_fail++; $display("FAIL impulse_latency[%0d]: got %0d required %0d", i, got_e_q[i] - acc_e_q[i], NTAPS + 1); end
        end
        if (acc_e_q.size() >= 2) begin
            n_checks++; if (acc_e_q[1] - acc_e_q[0] != NTAPS + 2) begin n_fail++; $display("FAIL impulse_throughput: got %0d required %0d", acc_e_q[1] - acc_e_q[0], NTAPS + 2); end
        end
    endtask

    task automatic test_max_magnitude();
        for (int k = 0; k < NTAPS; k++) cfg_write(k, 16'h7FFF);
        clear_sb();
        for (int i = 0; i < NTAPS; i++) send(16'h7FFF);
        drain();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL maxpos_model[%0d]: got %0d required %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
        if (got_q.size() == NTAPS) begin
            n_checks++; if (got_q[NTAPS-1] !== 35'd17178820624) begin n_fail++; $display("FAIL maxpos_y15: got %0d required 17178820624", $signed(got_q[NTAPS-1])); end
        end
        for (int k = 0; k < NTAPS; k++) cfg_write(k, 16'h8000);
        clear_sb();
        for (int i = 0; i < NTAPS; i++) send(16'h8000);
        drain();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL maxneg_model[%0d]: got %0d required %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
        if (got_q.size() == NTAPS) begin
            n_checks++; if (got_q[NTAPS-1] !== 35'h4_0000_0000) begin n_fail++; $display("FAIL maxneg_y15: got %0d required -17179869184", $signed(got_q[NTAPS-1])); end
        end
    endtask

    task automatic test_backpressure();
        logic [ACC_W-1:0] held;
        int i;
        clear_sb();
        m_ready = 1'b0;
        send(16'd3);
        s_valid = 1'b1;
        s_data  = 16'd7;
        i = 0;
        while (!m_valid && i < 50) begin
            tick();
            i++;
        end
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid_rise: got %b required 1", m_valid); end
        held = m_data;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid_hold[%0d]: got %b required 1", c, m_valid); end
            n_checks++; if (m_data !== held) begin n_fail++; $display("FAIL bp_m_data_hold[%0d]: got %0d required %0d", c, m_data, held); end
            n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready[%0d]: got %b required 0", c, s_ready); end
            tick();
        end
        n_checks++; if (exp_q.size() != 1) begin n_fail++; $display("FAIL bp_pending_taken: got %0d accepted required 1", exp_q.size()); end
        if (exp_q.size() >= 1) begin
            n_checks++; if (held !== exp_q[0]) begin n_fail++; $display("FAIL bp_held_value: got %0d required %0d", held, exp_q[0]); end
        end
        m_ready = 1'b1;
        tick();
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_s_ready_after: got %b required 1", s_ready); end
        tick();
        s_valid = 1'b0;
        n_checks++; if (acc_e_q.size() != 2) begin n_fail++; $display("FAIL bp_accept_count: got %0d required 2", acc_e_q.size()); end
        if (acc_e_q.size() == 2 && got_e_q.size() >= 1) begin
            n_checks++; if (acc_e_q[1] != got_e_q[0] + 1) begin n_fail++; $display("FAIL bp_accept_edge: got %0d required %0d", acc_e_q[1], got_e_q[0] + 1); end
        end
        drain();
        for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
            n_checks++; if (got_q[j] !== exp_q[j]) begin n_fail++; $display("FAIL bp_model[%0d]: got %0d required %0d", j, $signed(got_q[j]), $signed(exp_q[j])); end
        end
    endtask

    task automatic test_cfg_busy();
        for (int k = 0; k < NTAPS; k++) cfg_write(k, CW'(k + 1));
        flush_zeros();
        send(16'd1);
        tick();
        tick();
        tick();
        cfg_we   = 1'b1;
        cfg_addr = 4'd3;
        cfg_data = 16'd100;
        n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL busy_flag: got %b required 1", cfg_busy); end
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) send('0);
        drain();
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL busy_count: got %0d required 4", got_q.size()); end
        if (got_q.size() == 4) begin
            n_checks++; if (got_q[3] !== 35'd4) begin n_fail++; $display("FAIL busy_write_dropped: got %0d required 4", got_q[3]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_model[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); end
        end
        cfg_write(3, 16'd100);
        clear_sb();
        send(16'd1);
        for (int i = 0; i < 3; i++) send('0);
        drain();
        if (got_q.size() == 4) begin
            n_checks++; if (got_q[3] !== 35'd108) begin n_fail++; $display("FAIL idle_write_applied: got %0d required 108", got_q[3]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL idle_model[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_mac();
        int mv;
        clear_sb();
        send(16'd1);
        for (int i = 0; i < 7; i++) tick();
        n_checks++; if (mul_b !== 16'd8) begin n_fail++; $display("FAIL midmac_mul_b_k7: got %0d required 8", mul_b); end
        #2;
        ap_rst_n = 1'b0;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_s_ready: got %b required 0", s_ready); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid: got %b required 0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL midrst_m_data: got %0h required 0", m_data); end
        n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_cfg_busy: got %b required 0", cfg_busy); end
        n_checks++; if (mul_a !== '0) begin n_fail++; $display("FAIL midrst_mul_a: got %0h required 0", mul_a); end
        n_checks++; if (mul_b !== '0) begin n_fail++; $display("FAIL midrst_mul_b: got %0h required 0", mul_b); end
        model_clear();
        clear_sb();
        tick();
        tick();
        ap_rst_n = 1'b1;
        mv = 0;
        for (int i = 0; i < 30; i++) begin
            if (m_valid) mv++;
            tick();
        end
        n_checks++; if (mv != 0) begin n_fail++; $display("FAIL midrst_no_output: got %0d m_valid cycles required 0", mv); end
        send(16'd1);
        for (int i = 0; i < 3; i++) send('0);
        drain();
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL midrst_count: got %0d required 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== '0) begin n_fail++; $display("FAIL midrst_zero_y[%0d]: got %0d required 0", i, got_q[i]); end
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_model[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cfg_same_cycle();
        clear_sb();
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 16'd5;
        s_valid  = 1'b1;
        s_data   = 16'd2;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL same_s_ready: got %b required 1", s_ready); end
        tick();
        cfg_we  = 1'b0;
        s_valid = 1'b0;
        drain();
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL same_count: got %0d required 1", got_q.size()); end
        if (got_q.size() >= 1 && exp_q.size() >= 1) begin
            n_checks++; if (got_q[0] !== 35'd10) begin n_fail++; $display("FAIL same_y: got %0d required 10", got_q[0]); end
            n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL same_model: got %0d required %0d", got_q[0], exp_q[0]); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_max_magnitude();
        test_backpressure();
        test_cfg_busy();
        test_reset_mid_mac();
        test_cfg_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR controller that drives one shared 16×16 signed combinational multiplier. The multiplier sits outside this block, and the block sequences it through all taps for each input sample. It owns the sample delay line, the coefficient register file and the accumulator, and presents results on a valid/ready stream. The block sits between the sample source and the downstream decimation/interpolation stages, and one multiplier instance serves an NTAPS-tap filter.

## Interface
Parameters:
- NTAPS, 16: number of taps; power of two, 2..64.
- DW, 16: sample width, signed.
- CW, 16: coefficient width, signed.
- PW, 31: multiplier product width (DW+CW-1), signed.
- ACC_W, 35: accumulator/output width (PW+clog2(NTAPS)), signed.

Ports:
- ap_clk, in, 1: clock; all state changes on the rising edge.
- ap_rst_n, in, 1: reset; asynchronous assert, active-low.
- s_valid, in, 1: input sample valid.
- s_ready, out, 1: block can accept a sample.
- s_data, in, DW: input sample.
- m_valid, out, 1: filter result valid.
- m_ready, in, 1: downstream accepts result.
- m_data, out, ACC_W: filter result.
- cfg_we, in, 1: coefficient write strobe.
- cfg_addr, in, clog2(NTAPS): coefficient index.
- cfg_data, in, CW: coefficient value.
- cfg_busy, out, 1: high whenever state is not IDLE; writes are dropped while high.
- mul_a, out, DW: multiplier operand A (sample).
- mul_b, out, CW: multiplier operand B (coefficient).
- mul_p, in, PW: multiplier product. Combinational from mul_a/mul_b in the same cycle.

## Operation
- State machine has three states: IDLE, MAC, OUT. Tap counter k runs from 0 to NTAPS-1.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready: shift the delay line (x[j]←x[j-1], x[0]←s_data), clear acc, set k=0, go to MAC.
- MAC:
  - Drive mul_a=x[k] and mul_b=coef[k].
  - acc ← acc + sign_extend(mul_p).
  - When k==NTAPS-1, go to OUT; otherwise increment k.
- OUT:
  - m_valid=1 and m_data=acc, both held stable until m_ready.
  - On m_valid&&m_ready, go to IDLE.
  - s_ready=0 in MAC and OUT.
- Result: y[n]=Σ coef[k]·x[n-k], k=0..NTAPS-1.
- Arithmetic:
  - Two's complement throughout; acc wraps modulo 2^ACC_W with no saturation.
  - mul_p is taken as delivered. (-2^(DW-1))·(-2^(CW-1)) wraps to -2^(PW-1) at the multiplier, and the block does not correct it.
- Coefficient writes:
  - A write occurs on cfg_we and takes effect the next cycle, only when state==IDLE.
  - A write presented in the same cycle as a sample is accepted completes before MAC starts, so the new coefficient applies to that sample.
  - Writes with cfg_busy=1 are dropped silently.
- mul_a and mul_b are 0 outside MAC, to keep the shared multiplier quiet.
- Reset (ap_rst_n low, any state, including mid-MAC):
  - State→IDLE; k, acc, delay line and all coefficients→0.
  - s_ready=0 while reset is asserted, and 1 in the first cycle after release.
  - m_valid=0, m_data=0, cfg_busy=0, mul_a=0, mul_b=0.
  - A result in progress is discarded and never emitted.

## Timing
- Sample accepted at edge 0.
- MAC occupies cycles 1..NTAPS.
- m_valid rises in cycle NTAPS+1, giving latency NTAPS+1 cycles from acceptance to first m_valid.
- With m_ready tied high, s_ready returns in cycle NTAPS+2. Peak throughput is one sample per NTAPS+2 cycles.
- m_ready low stalls indefinitely in OUT. m_data and m_valid must not change while stalled, and no new sample is accepted.
- s_valid may be held high across busy periods. The sample is taken only in a cycle with s_ready=1, and exactly one sample is taken per IDLE visit.
- No combinational path from s_valid to s_ready, or from m_ready to m_valid.

## Test plan
- **Impulse:** coef[k]=k+1; feed 1 then 17 zeros with m_ready=1 → m_data=1,2,…,16,0,0. Each output appears 17 cycles after its sample's acceptance.
- **Max magnitude:** all coef=32767; feed 16 samples of 32767 → 16th output=17178820624 with no wrap. Then all coef=-32768 and inputs -32768 → each MAC product is -2^30, and the accumulated result matches a model that applies the multiplier's wrap.
- **Backpressure:** hold m_ready=0 for 10 cycles in OUT → m_data stable, s_ready=0, pending s_valid not consumed. Raise m_ready → handshake completes and the sample is accepted the next cycle.
- **Config while busy:** write coef[3]=100 during MAC → cfg_busy=1 and the write is dropped (impulse output at tap 3 is unchanged). Repeat the write in IDLE → it takes effect on the next sample.
- **Reset mid-MAC:** assert ap_rst_n low at k=7 → all outputs 0 immediately and no m_valid afterward. The next impulse after release yields all-zero output because coefficients were cleared.
- **Coefficient/sample same cycle:** cfg_we with coef[0]=5 in the same cycle as s_valid with sample 2 in IDLE → first output=10.
